// File: rtl/microcode_pkg.sv
// Shared encodings and the PE enable table for the microcode sequencer.
package microcode_pkg;

  localparam int unsigned OP_W     = 2;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned PE_TBL_W = 11;

  localparam int unsigned CMD_ADD   = 4;
  localparam int unsigned CMD_SUB   = 8;
  localparam int unsigned CMD_CUBIC = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_CUBIC = 2'd2,
    OP_MULT  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_READ_SRC1 = 3'd2,
    S_READ_SRC2 = 3'd3,
    S_CALC      = 3'd4,
    S_WAIT      = 3'd5,
    S_WRITE     = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  // PE enable mask for the current state/op; zero outside the read/calc phases.
  function automatic logic [PE_TBL_W-1:0] pe_lookup(input state_e st, input op_e op);
    logic [PE_TBL_W-1:0] m;
    m = '0;
    case (st)
      S_READ_SRC1: begin
        case (op)
          OP_ADD, OP_SUB: m = 11'b11001000000;
          OP_CUBIC:       m = 11'b11111000000;
          OP_MULT:        m = 11'b11110000000;
        endcase
      end
      S_READ_SRC2: begin
        case (op)
          OP_ADD, OP_SUB: m = 11'b00110000000;
          OP_CUBIC:       m = 11'b00000000000;
          OP_MULT:        m = 11'b00001000000;
        endcase
      end
      S_CALC: begin
        case (op)
          OP_ADD, OP_SUB: m = 11'b00000010001;
          OP_CUBIC:       m = 11'b01010000001;
          OP_MULT:        m = 11'b00000111111;
        endcase
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/microcode_sequencer_loop_unit.sv
// Hardware loop counters with lowest-index priority match on loop-end addresses.
module microcode_sequencer_loop_unit
  import microcode_pkg::*;
#(
  parameter int unsigned ROM_AW    = 9,
  parameter int unsigned NUM_LOOPS = 2,
  parameter logic [NUM_LOOPS*ROM_AW-1:0] LOOP_START = {9'd280, 9'd22},
  parameter logic [NUM_LOOPS*ROM_AW-1:0] LOOP_END   = {9'd293, 9'd117},
  parameter logic [NUM_LOOPS*CNT_W-1:0]  LOOP_ITERS = {8'd48, 8'd48}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              step,
  input  logic [ROM_AW-1:0] cur_addr,
  output logic [ROM_AW-1:0] next_rom_addr_c
);

  logic [NUM_LOOPS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_LOOPS-1:0][CNT_W-1:0] cnt_d;
  logic [NUM_LOOPS-1:0][CNT_W-1:0] rearm_c;
  logic                            matched;

  // Re-arm value of every counter: body executions minus the first pass.
  always_comb begin
    rearm_c = '0;
    for (int i = 0; i < int'(NUM_LOOPS); i++) begin
      rearm_c[i] = LOOP_ITERS[i*CNT_W +: CNT_W] - CNT_W'(1);
    end
  end

  // Next command address and counter update; only the lowest matching loop acts.
  always_comb begin
    next_rom_addr_c = cur_addr + ROM_AW'(1);
    cnt_d           = cnt_q;
    matched         = 1'b0;
    for (int i = 0; i < int'(NUM_LOOPS); i++) begin
      if (!matched && (cur_addr == LOOP_END[i*ROM_AW +: ROM_AW])) begin
        matched = 1'b1;
        if (cnt_q[i] != '0) begin
          next_rom_addr_c = LOOP_START[i*ROM_AW +: ROM_AW];
          if (step) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else if (step) begin
          cnt_d[i] = rearm_c[i];
        end
      end
    end
    if (reload) cnt_d = rearm_c;
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= rearm_c;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: walks the command ROM and drives RAM A/B addressing and PE enables.
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int unsigned ROM_AW    = 9,
  parameter int unsigned RAM_AW    = 6,
  parameter int unsigned TIMES_W   = 6,
  parameter int unsigned PE_W      = 11,
  parameter int unsigned NUM_LOOPS = 2,
  parameter logic [NUM_LOOPS*ROM_AW-1:0] LOOP_START = {9'd280, 9'd22},
  parameter logic [NUM_LOOPS*ROM_AW-1:0] LOOP_END   = {9'd293, 9'd117},
  parameter logic [NUM_LOOPS*CNT_W-1:0]  LOOP_ITERS = {8'd48, 8'd48}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic [ROM_AW-1:0]                 rom_addr,
  input  logic [3*RAM_AW+OP_W+TIMES_W-1:0]  rom_q,
  output logic [RAM_AW-1:0]                 ram_a_addr,
  output logic [RAM_AW-1:0]                 ram_b_addr,
  output logic                              ram_b_w,
  output logic [PE_W-1:0]                   pe,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned TIMES_LSB = RAM_AW;
  localparam int unsigned OP_LSB    = TIMES_LSB + TIMES_W;
  localparam int unsigned SRC1_LSB  = OP_LSB + OP_W;
  localparam int unsigned DEST_LSB  = SRC1_LSB + RAM_AW;

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [TIMES_W-1:0]  count_q, count_d;
  logic [PE_W-1:0]     pe_q, pe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [RAM_AW-1:0]   dest_c, src1_c, src2_c;
  logic [TIMES_W-1:0]  times_c;
  op_e                 op_c;
  logic                reload_c, step_c;
  logic [ROM_AW-1:0]   next_rom_addr_c;

  // Command word fields: {dest, src1, op, times, src2}.
  always_comb begin
    src2_c  = rom_q[RAM_AW-1:0];
    times_c = rom_q[TIMES_LSB +: TIMES_W];
    op_c    = op_e'(rom_q[OP_LSB +: OP_W]);
    src1_c  = rom_q[SRC1_LSB +: RAM_AW];
    dest_c  = rom_q[DEST_LSB +: RAM_AW];
  end

  microcode_sequencer_loop_unit #(
    .ROM_AW     (ROM_AW),
    .NUM_LOOPS  (NUM_LOOPS),
    .LOOP_START (LOOP_START),
    .LOOP_END   (LOOP_END),
    .LOOP_ITERS (LOOP_ITERS)
  ) u_loop (
    .clk             (clk),
    .reset           (reset),
    .reload          (reload_c),
    .step            (step_c),
    .cur_addr        (rom_addr_q),
    .next_rom_addr_c (next_rom_addr_c)
  );

  // Next-state logic plus combinational RAM strobes.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    count_d    = count_q;
    reload_c   = 1'b0;
    step_c     = 1'b0;
    ram_a_addr = '0;
    ram_b_addr = '0;
    ram_b_w    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
          reload_c   = 1'b1;
        end
      end
      S_FETCH: state_d = S_READ_SRC1;
      S_READ_SRC1: begin
        state_d    = S_READ_SRC2;
        count_d    = times_c;
        ram_a_addr = src1_c;
        case (op_c)
          OP_ADD:   ram_b_addr = RAM_AW'(CMD_ADD);
          OP_SUB:   ram_b_addr = RAM_AW'(CMD_SUB);
          OP_CUBIC: ram_b_addr = RAM_AW'(CMD_CUBIC);
          OP_MULT:  ram_b_addr = '0;
        endcase
      end
      S_READ_SRC2: begin
        ram_a_addr = src2_c;
        ram_b_addr = src2_c;
        state_d    = (times_c == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        count_d = count_q - TIMES_W'(1);
        if (count_q == TIMES_W'(1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        step_c     = 1'b1;
        rom_addr_d = next_rom_addr_c;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        ram_b_w    = 1'b1;
        ram_b_addr = dest_c;
        state_d    = S_READ_SRC1;
      end
      default: state_d = S_IDLE;
    endcase
    pe_d   = PE_W'(pe_lookup(state_q, op_c));
    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      count_q    <= '0;
      pe_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      count_q    <= count_d;
      pe_q       <= pe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pe       = pe_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: three loop configurations, RAM B writes scoreboarded.
module tb_microcode_sequencer;

  localparam int unsigned ROM_AW  = 9;
  localparam int unsigned RAM_AW  = 6;
  localparam int unsigned TIMES_W = 6;
  localparam int unsigned PE_W    = 11;
  localparam int unsigned CW      = 3*RAM_AW + 2 + TIMES_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [RAM_AW-1:0] sb_q[$];

  // Instance A: single loop 2..3 x4
  logic reset_a, start_a, ram_b_w_a, busy_a, done_a;
  logic [ROM_AW-1:0]  rom_addr_a;
  logic [CW-1:0]      rom_q_a;
  logic [RAM_AW-1:0]  ram_a_addr_a, ram_b_addr_a;
  logic [PE_W-1:0]    pe_a;
  logic [CW-1:0]      mem_a [16];
  always @(posedge clk) rom_q_a <= mem_a[rom_addr_a[3:0]];

  microcode_sequencer #(
    .NUM_LOOPS(1), .LOOP_START(9'd2), .LOOP_END(9'd3), .LOOP_ITERS(8'd4)
  ) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .rom_addr(rom_addr_a), .rom_q(rom_q_a),
    .ram_a_addr(ram_a_addr_a), .ram_b_addr(ram_b_addr_a), .ram_b_w(ram_b_w_a),
    .pe(pe_a), .busy(busy_a), .done(done_a)
  );

  // Instance B: inner loop0 3..4 x2 nested in outer loop1 2..5 x3
  logic reset_b, start_b, ram_b_w_b, busy_b, done_b;
  logic [ROM_AW-1:0]  rom_addr_b;
  logic [CW-1:0]      rom_q_b;
  logic [RAM_AW-1:0]  ram_a_addr_b, ram_b_addr_b;
  logic [PE_W-1:0]    pe_b;
  logic [CW-1:0]      mem_b [16];
  always @(posedge clk) rom_q_b <= mem_b[rom_addr_b[3:0]];

  microcode_sequencer #(
    .NUM_LOOPS(2), .LOOP_START({9'd2, 9'd3}), .LOOP_END({9'd5, 9'd4}), .LOOP_ITERS({8'd3, 8'd2})
  ) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .rom_addr(rom_addr_b), .rom_q(rom_q_b),
    .ram_a_addr(ram_a_addr_b), .ram_b_addr(ram_b_addr_b), .ram_b_w(ram_b_w_b),
    .pe(pe_b), .busy(busy_b), .done(done_b)
  );

  // Instance C: both loops end at 7
  logic reset_c, start_c, ram_b_w_c, busy_c, done_c;
  logic [ROM_AW-1:0]  rom_addr_c;
  logic [CW-1:0]      rom_q_c;
  logic [RAM_AW-1:0]  ram_a_addr_c, ram_b_addr_c;
  logic [PE_W-1:0]    pe_c;
  logic [CW-1:0]      mem_c [16];
  always @(posedge clk) rom_q_c <= mem_c[rom_addr_c[3:0]];

  microcode_sequencer #(
    .NUM_LOOPS(2), .LOOP_START({9'd5, 9'd6}), .LOOP_END({9'd7, 9'd7}), .LOOP_ITERS({8'd2, 8'd2})
  ) dut_c (
    .clk(clk), .reset(reset_c), .start(start_c), .rom_addr(rom_addr_c), .rom_q(rom_q_c),
    .ram_a_addr(ram_a_addr_c), .ram_b_addr(ram_b_addr_c), .ram_b_w(ram_b_w_c),
    .pe(pe_c), .busy(busy_c), .done(done_c)
  );

  function automatic logic [CW-1:0] cmd(input int d, input int s1, input int op, input int t, input int s2);
    return {RAM_AW'(d), RAM_AW'(s1), 2'(op), TIMES_W'(t), RAM_AW'(s2)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [RAM_AW-1:0] obs);
    logic [RAM_AW-1:0] exp;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s unexpected write observed=%0h expected=none", tag, obs);
    end
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  // Every RAM B write must match the next expected destination.
  always @(negedge clk) begin
    if (ram_b_w_a) sb_pop("wr_a", ram_b_addr_a);
    if (ram_b_w_b) sb_pop("wr_b", ram_b_addr_b);
    if (ram_b_w_c) sb_pop("wr_c", ram_b_addr_c);
  end

  function automatic logic done_of(input int w);
    return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
  endfunction

  task automatic pulse_start(input int w);
    if (w == 0) start_a = 1'b1; else if (w == 1) start_b = 1'b1; else start_c = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int w, input int budget);
    int n;
    n = 0;
    while ((n < budget) && !done_of(w)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done_of(w)), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; mem_c[i] = '0;
    end
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;

    // Reset state
    chk("rst_rom_addr", 32'(rom_addr_a), 32'd0);
    chk("rst_pe",       32'(pe_a),       32'd0);
    chk("rst_done",     32'(done_a),     32'd0);
    chk("rst_busy",     32'(busy_a),     32'd0);
    chk("rst_cnt",      32'(dut_a.u_loop.cnt_q[0]), 32'd3);

    // Single ADD command times=3 then terminator
    mem_a[0] = cmd(5, 1, 0, 3, 2);
    mem_a[1] = cmd(9, 7, 0, 0, 8);
    sb_q.push_back(RAM_AW'(5));
    pulse_start(0);                                    // FETCH
    chk("t1_fetch_busy", 32'(busy_a), 32'd1);
    chk("t1_fetch_addr", 32'(rom_addr_a), 32'd0);
    @(negedge clk);                                    // READ_SRC1
    chk("t1_rs1_a", 32'(ram_a_addr_a), 32'd1);
    chk("t1_rs1_b", 32'(ram_b_addr_a), 32'd4);
    chk("t1_rs1_w", 32'(ram_b_w_a), 32'd0);
    @(negedge clk);                                    // READ_SRC2
    chk("t1_rs2_a", 32'(ram_a_addr_a), 32'd2);
    chk("t1_rs2_b", 32'(ram_b_addr_a), 32'd2);
    chk("t1_rs2_pe", 32'(pe_a), 32'b11001000000);
    @(negedge clk);                                    // CALC 1
    chk("t1_calc_a", 32'(ram_a_addr_a), 32'd0);
    chk("t1_calc1_pe", 32'(pe_a), 32'b00110000000);
    start_a = 1'b1;                                    // ignored while busy
    @(negedge clk);                                    // CALC 2
    start_a = 1'b0;
    chk("t1_calc2_pe", 32'(pe_a), 32'b00000010001);
    chk("t1_calc2_busy", 32'(busy_a), 32'd1);
    @(negedge clk);                                    // CALC 3
    chk("t1_calc3_w", 32'(ram_b_w_a), 32'd0);
    @(negedge clk);                                    // WAIT
    chk("t1_wait_w", 32'(ram_b_w_a), 32'd0);
    chk("t1_wait_addr", 32'(rom_addr_a), 32'd0);
    @(negedge clk);                                    // WRITE, 7th cycle of the command
    chk("t1_write_w", 32'(ram_b_w_a), 32'd1);
    chk("t1_write_b", 32'(ram_b_addr_a), 32'd5);
    chk("t1_write_addr", 32'(rom_addr_a), 32'd1);
    chk("t1_write_pe", 32'(pe_a), 32'd0);
    @(negedge clk);                                    // READ_SRC1 of cmd 1
    chk("t1_c1_rs1_a", 32'(ram_a_addr_a), 32'd7);
    @(negedge clk);                                    // READ_SRC2 of cmd 1
    chk("t1_c1_rs2_a", 32'(ram_a_addr_a), 32'd8);
    @(negedge clk);                                    // DONE
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("t1_done_hold", 32'(done_a), 32'd1);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Loop 2..3 x4, restarted from DONE
    for (int i = 0; i < 5; i++) mem_a[i] = cmd(i, i, 3, 1, i);
    mem_a[5] = cmd(5, 5, 3, 0, 5);
    sb_q.push_back(RAM_AW'(0)); sb_q.push_back(RAM_AW'(1));
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(RAM_AW'(2)); sb_q.push_back(RAM_AW'(3));
    end
    sb_q.push_back(RAM_AW'(4));
    pulse_start(0);
    chk("t2_restart_busy", 32'(busy_a), 32'd1);
    chk("t2_restart_addr", 32'(rom_addr_a), 32'd0);
    wait_done("t2_done", 0, 200);
    chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("t2_cnt_rearm", 32'(dut_a.u_loop.cnt_q[0]), 32'd3);

    // Reset during CALC aborts the program
    mem_a[0] = cmd(1, 1, 3, 5, 1);
    pulse_start(0);                                    // FETCH
    repeat (3) @(negedge clk);                         // CALC 1
    chk("t3_calc_pe", 32'(pe_a), 32'b00001000000);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    chk("t3_rst_pe", 32'(pe_a), 32'd0);
    chk("t3_rst_addr", 32'(rom_addr_a), 32'd0);
    chk("t3_rst_busy", 32'(busy_a), 32'd0);
    chk("t3_rst_done", 32'(done_a), 32'd0);
    repeat (10) @(negedge clk);
    chk("t3_idle_busy", 32'(busy_a), 32'd0);
    chk("t3_idle_done", 32'(done_a), 32'd0);

    // Nested loops
    for (int i = 0; i < 6; i++) mem_b[i] = cmd(i, i, 1, 1, i);
    mem_b[6] = cmd(6, 6, 1, 0, 6);
    sb_q.push_back(RAM_AW'(0)); sb_q.push_back(RAM_AW'(1));
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(RAM_AW'(2));
      sb_q.push_back(RAM_AW'(3)); sb_q.push_back(RAM_AW'(4));
      sb_q.push_back(RAM_AW'(3)); sb_q.push_back(RAM_AW'(4));
      sb_q.push_back(RAM_AW'(5));
    end
    pulse_start(1);
    wait_done("t4_done", 1, 400);
    chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("t4_cnt0", 32'(dut_b.u_loop.cnt_q[0]), 32'd1);
    chk("t4_cnt1", 32'(dut_b.u_loop.cnt_q[1]), 32'd2);

    // Shared loop end: loop 0 wins, loop 1 untouched
    for (int i = 0; i < 8; i++) mem_c[i] = cmd(i, i, 2, 1, i);
    mem_c[8] = cmd(8, 8, 2, 0, 8);
    for (int i = 0; i < 8; i++) sb_q.push_back(RAM_AW'(i));
    sb_q.push_back(RAM_AW'(6)); sb_q.push_back(RAM_AW'(7));
    pulse_start(2);
    wait_done("t5_done", 2, 300);
    chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("t5_cnt0", 32'(dut_c.u_loop.cnt_q[0]), 32'd1);
    chk("t5_cnt1", 32'(dut_c.u_loop.cnt_q[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
